// File: rtl/uart_pkg.sv
// Shared UART constants and serializer state encoding.
// Parity support in uart_byte_tx is enabled by defining UART_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned STOP_BITS       = 1;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the upstream handshake and the UART serializer.
// Callers only push when not full and only pop when not empty.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = !(count < DEPTH_C);
    assign empty    = (count == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART byte transmitter; define UART_PARITY_EN for 8E1 framing.
// Back-to-back frames are sent with no idle gap while the FIFO has data.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       busy
);
    import uart_pkg::*;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t                    state;
    logic [15:0]                  bit_cnt;
    logic [2:0]                   bit_idx;
    logic [7:0]                   shift;
    logic                         bit_done;
    logic                         push;
    logic                         pop;
    logic [7:0]                   head;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
`ifdef UART_PARITY_EN
    logic                         parity_bit;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign bit_done = (bit_cnt == LAST_CNT);
    assign pop      = !fifo_empty &&
                      ((state == ST_IDLE) || (state == ST_STOP && bit_done));
    assign busy     = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= UART_IDLE_LEVEL;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (state != ST_IDLE) begin
                bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_done) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                            state    <= ST_PARITY;
                            uart_txd <= parity_bit;
`else
                            state    <= ST_STOP;
                            uart_txd <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shift    <= shift >> 1;
                            uart_txd <= shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state    <= ST_STOP;
                        uart_txd <= UART_IDLE_LEVEL;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A pop (from IDLE or at end of STOP) overrides the case above and starts the next frame.
            if (pop) begin
                state    <= ST_START;
                shift    <= head;
                uart_txd <= ~UART_IDLE_LEVEL;
`ifdef UART_PARITY_EN
                parity_bit <= even_parity(head);
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Frame length and parity expectations follow UART_PARITY_EN.
module tb_uart_byte_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] EXP_FRAME_47 = 11'b100_1000_1110;
    localparam logic [10:0] EXP_FRAME_31 = 11'b110_0110_0010;
`else
    localparam int NBITS = 10;
    localparam logic [10:0] EXP_FRAME_47 = 11'b010_1000_1110;
    localparam logic [10:0] EXP_FRAME_31 = 11'b010_0110_0010;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       uart_txd;
    logic       busy;

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    logic [7:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted byte is expected on the line, in order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && tx_valid && tx_ready) exp_q.push_back(tx_data);
    end

    int          frames_started = 0;
    int          frames_done    = 0;
    int          b2b            = 0;
    int unsigned last_end       = 0;
    logic        mon_busy       = 1'b0;
    logic [10:0] last_bits      = '0;

    initial begin : monitor
        logic [10:0] bits;
        logic        stable;
        logic        aborted;
        logic [7:0]  exp;
        forever begin
            @(posedge clk); #1;
            if (reset_n && uart_txd == 1'b0) begin
                mon_busy = 1'b1;
                frames_started++;
                if (frames_done > 0 && cyc == last_end + 1) b2b++;
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < NBITS && !aborted; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk); #1;
                        end
                        if (!reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = uart_txd;
                        else if (uart_txd !== bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    last_end  = cyc;
                    last_bits = bits;
                    frames_done++;
                    check_eq("bit_stable", stable, 1);
                    check_eq("stop_bit", bits[NBITS-1], 1);
                    check_eq("sb_has_entry", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        check_eq("rx_byte", bits[8:1], exp);
`ifdef UART_PARITY_EN
                        check_eq("parity_bit", bits[9], ^exp);
`endif
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || mon_busy) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("wait_idle", busy || mon_busy, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] stream_bytes [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    logic [7:0] gcode_bytes  [8] = '{8'h47, 8'h39, 8'h30, 8'h0A, 8'h47, 8'h32, 8'h31, 8'h0A};

    initial begin : main
        int n;
        int g;
        int stall_at;
        int b2b_before;
        int done_before;
        int fs;
        int lows;

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_txd", uart_txd, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single byte: latency, frame contents, busy timing.
        push_byte(8'h47);
        check_eq("lat_pre_txd", uart_txd, 1);
        @(posedge clk); #1;
        check_eq("lat_fall_txd", uart_txd, 0);
        n = 1;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("busy_fall_cycles", n, FRAME_CYC + 1);
        wait_idle();
        check_eq("frame_47", last_bits, EXP_FRAME_47);

        push_byte(8'h31);
        wait_idle();
        check_eq("frame_31", last_bits, EXP_FRAME_31);

        // Held tx_valid with six bytes: stall after FIFO fills, frames back to back.
        b2b_before = b2b;
        stall_at   = -1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tx_data  = stream_bytes[i];
            tx_valid = 1'b1;
            g = 0;
            while (!tx_ready && g < 300) begin
                if (stall_at < 0) stall_at = i;
                @(negedge clk);
                g++;
            end
            if (g >= 300) check_eq("stream_ready_timeout", tx_ready, 1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check_eq("stall_after_accepts", stall_at, DEPTH + 1);
        wait_idle();
        check_eq("stream_b2b_frames", b2b - b2b_before, 5);

        // G-code strings as one-cycle pulses two cycles apart.
        done_before = frames_done;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            g = 0;
            while (!tx_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            tx_data  = gcode_bytes[i];
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            @(negedge clk);
        end
        wait_idle();
        check_eq("gcode_frames", frames_done - done_before, 8);

        // Push coinciding with the STOP->START pop while three bytes are queued.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        repeat (FRAME_CYC - 3) @(posedge clk);
        push_byte(8'h55);
        check_eq("coincide_ready", tx_ready, 1);
        push_byte(8'h66);
        check_eq("ready_after_fill", tx_ready, 0);
        push_byte(8'hEE);
        check_eq("ready_after_drop", tx_ready, 0);
        wait_idle();

        // Reset during DATA bit 3 with two bytes queued.
        push_byte(8'hC3);
        push_byte(8'h5A);
        push_byte(8'hA5);
        repeat (16) @(posedge clk);
        #2;
        check_eq("pre_reset_txd", uart_txd, 0);
        reset_n = 1'b0;
        #1;
        check_eq("reset_txd", uart_txd, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_ready", tx_ready, 1);
        exp_q.delete();
        fs = frames_started;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (!uart_txd) lows++;
        end
        check_eq("post_reset_txd_lows", lows, 0);
        check_eq("post_reset_frames", frames_started - fs, 0);
        check_eq("post_reset_busy", busy, 0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning bytes buffered between the handshake and the serializer; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port tx_valid  input  1  upstream byte-offer strobe.
REQ-006 SHALL have port tx_data  input  8  upstream G-code byte, sampled only on handshake.
REQ-007 SHALL have port tx_ready  output  1  high when a byte can be accepted this cycle.
REQ-008 SHALL have port uart_txd  output  1  serial line to the plotter controller, idle high.
REQ-009 SHALL have port busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Function
REQ-010 SHALL accept a byte on every rising edge where tx_valid and tx_ready are both high; a single-cycle tx_valid pulse is sufficient.
REQ-011 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), combinationally from registered count; a byte offered while tx_ready is low is dropped, not stalled.
REQ-012 SHALL keep FIFO order: bytes leave uart_txd in acceptance order.
REQ-013 SHALL leave fifo_count unchanged on a simultaneous push and pop, including when the FIFO holds FIFO_DEPTH-1 bytes.
REQ-014 SHALL wrap read/write pointers modulo FIFO_DEPTH without loss or duplication.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL move IDLE->START on the edge where the FIFO is non-empty, popping the head byte into a shift register on that same edge.
REQ-017 SHALL hold each of START (txd=0), each DATA bit, PARITY and STOP (txd=1) for exactly CLKS_PER_BIT cycles via a bit-period counter reset at every state/bit change.
REQ-018 SHALL send DATA LSB first, 8 bits, tracked by a 3-bit index; DATA->PARITY or ->STOP after index 7.
REQ-019 SHALL move STOP->START directly, with no idle cycle, if the FIFO is non-empty at the end of STOP; else STOP->IDLE.
REQ-020 SHALL produce latency of exactly one cycle from handshake into an empty, IDLE block to uart_txd falling.
REQ-021 SHALL drive uart_txd from a register (glitch-free); it is 1 in IDLE.
REQ-022 SHALL drive busy = (state != IDLE) or (fifo_count != 0).

Reset
REQ-023 SHALL, while reset_n is low, force state=IDLE, uart_txd=1, fifo_count=0, pointers=0, bit counter=0, tx_ready=1, busy=0.
REQ-024 SHALL abandon a frame in progress when reset asserts mid-frame: uart_txd returns high immediately, buffered bytes are discarded.

Configuration
REQ-025 SHALL, with UART_PARITY_EN defined, insert the PARITY state after DATA, transmitting even parity (XOR of the 8 data bits); frame = 11 bit periods.
REQ-026 SHALL, without UART_PARITY_EN, never enter PARITY; frame = 10 bit periods.

Structure
REQ-027 SHALL take the FSM state enum, frame-bit constants (8 data bits, 1 stop bit) and the UART_IDLE_LEVEL constant from shared package uart_pkg.
REQ-028 SHALL put the FIFO in sub-module uart_tx_fifo (push/pop/count/full/empty); the serializer FSM stays in uart_byte_tx.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 SHALL cover: single pulse tx_data=0x47 ('G') -> txd low one cycle later, then bits 0,1,1,1,0,0,0,1,0,1 (start, LSB-first data, stop) at 4 cycles each, 40 cycles total, busy falls after STOP.
REQ-030 SHALL cover, with UART_PARITY_EN: 0x47 -> parity bit 0 inserted before stop, 44 cycles; 0x31 ('1') -> parity bit 1.
REQ-031 SHALL cover: tx_valid held high with 6 distinct bytes -> tx_ready low once 4 bytes are held; bytes accepted later resume in order, and back-to-back frames show no idle gap.
REQ-032 SHALL cover: push "G90\n" then "G21\n" via one-cycle pulses spaced 2 cycles apart -> all 8 bytes emitted in order with none lost.
REQ-033 SHALL cover: reset_n pulsed low during DATA bit 3 with 2 bytes queued -> txd=1 same cycle, busy=0, tx_ready=1, no further frames.
REQ-034 SHALL cover: push when count=3 coinciding with STOP->START pop -> count stays 3, tx_ready stays 1, order preserved.
